// File: rtl/rfid_spi_responder_pkg.sv
// Opcode table and encodings for the security-system SPI link.
// Both the master side and the reader-emulating slave import this package.
package rfid_spi_responder_pkg;

  localparam logic [7:0] CMD_UID        = 8'hAA;
  localparam logic [7:0] CMD_STATE_BASE = 8'hBA;
  localparam logic [7:0] IDLE_BYTE      = 8'h00;

  localparam logic [1:0] SYS_DISENGAGED = 2'd0;
  localparam logic [1:0] SYS_ENGAGED    = 2'd1;
  localparam logic [1:0] SYS_COUNTDOWN  = 2'd2;
  localparam logic [1:0] SYS_ALERT      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UID,
    S_STATE
  } seq_state_t;

  // Byte idx of a UID, byte 0 being the most significant.
  function automatic logic [7:0] uid_byte(input logic [31:0] uid, input logic [1:0] idx);
    case (idx)
      2'd0:    uid_byte = uid[31:24];
      2'd1:    uid_byte = uid[23:16];
      2'd2:    uid_byte = uid[15:8];
      default: uid_byte = uid[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rfid_spi_responder_spi_slave_byte.sv
// Mode-0 SPI slave byte engine: synchronises the SPI pins into CLOCK_50,
// shifts bytes in/out MSB first and flags completed or aborted bytes.
module spi_slave_byte #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_sclk,
  input  logic       i_ss_n,
  input  logic       i_mosi,
  input  logic [7:0] i_tx_byte,
  output logic       o_miso,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_abort
);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_ss_prev, r_active;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift, r_tx_shift, r_rx_byte;
  logic                   r_rx_valid, r_abort;

  logic w_sclk, w_ss, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise, w_last_bit;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_ss_fall   = ~w_ss & r_ss_prev;
  assign w_ss_rise   = w_ss & ~r_ss_prev;
  assign w_last_bit  = w_sclk_rise && (r_bit_cnt == 3'd7);

  always_ff @(posedge i_clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
    r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss_n};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
  end

  // Edge history tracks the pins through reset so that a slave select already
  // low at release is not mistaken for a new frame; r_active gates all shifting.
  always_ff @(posedge i_clk) begin
    r_sclk_prev <= w_sclk;
    r_ss_prev   <= w_ss;
    if (!i_reset_n) begin
      r_active   <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
      if (w_ss_fall) begin
        r_active   <= 1'b1;
        r_bit_cnt  <= '0;
        r_tx_shift <= i_tx_byte;
      end else if (r_active) begin
        if (w_sclk_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (w_last_bit) begin
            r_rx_byte  <= {r_rx_shift[6:0], w_mosi};
            r_rx_valid <= 1'b1;
          end
        end else if (w_sclk_fall) begin
          if (r_bit_cnt != 3'd0) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          else                   r_tx_shift <= i_tx_byte;
        end
        // A byte finishing on the same cycle as deselect still counts as complete.
        if (w_ss_rise) begin
          r_active  <= 1'b0;
          r_bit_cnt <= '0;
          if ((r_bit_cnt != 3'd0) && !w_last_bit) r_abort <= 1'b1;
        end
      end
    end
  end

  assign o_miso     = r_active & r_tx_shift[7];
  assign o_rx_byte  = r_rx_byte;
  assign o_rx_valid = r_rx_valid;
  assign o_abort    = r_abort;

endmodule

// File: rtl/rfid_spi_responder.sv
// RFID reader emulation on the SPI link: replies to UID polls with a snapshot
// of the presented card and captures the trailing system-state command.
module rfid_spi_responder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [7:0]  CMD_UID        = rfid_spi_responder_pkg::CMD_UID,
  parameter logic [7:0]  CMD_STATE_BASE = rfid_spi_responder_pkg::CMD_STATE_BASE,
  parameter logic [7:0]  IDLE_BYTE      = rfid_spi_responder_pkg::IDLE_BYTE
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [31:0] uid_in,
  input  logic        uid_present,
  output logic [1:0]  state_code,
  output logic        state_valid,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_error
);

  import rfid_spi_responder_pkg::*;

  seq_state_t  r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [31:0] r_uid, w_uid_nxt;
  logic [7:0]  r_next_tx, w_next_tx_nxt;
  logic [1:0]  r_state_code, w_state_code_nxt;
  logic        r_state_valid, w_state_valid_nxt;
  logic        r_frame_error, w_frame_error_nxt;
  logic        w_rx_valid, w_abort;
  logic [7:0]  w_rx_byte, w_state_ofs;

  spi_slave_byte #(.SYNC_STAGES(SYNC_STAGES)) u_byte (
    .i_clk      (CLOCK_50),
    .i_reset_n  (reset),
    .i_sclk     (spi_sclk),
    .i_ss_n     (spi_ss_n),
    .i_mosi     (spi_mosi),
    .i_tx_byte  (r_next_tx),
    .o_miso     (spi_miso),
    .o_rx_byte  (w_rx_byte),
    .o_rx_valid (w_rx_valid),
    .o_abort    (w_abort)
  );

  assign w_state_ofs = w_rx_byte - CMD_STATE_BASE;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_uid         <= '0;
      r_next_tx     <= '0;
      r_state_code  <= SYS_DISENGAGED;
      r_state_valid <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_uid         <= w_uid_nxt;
      r_next_tx     <= w_next_tx_nxt;
      r_state_code  <= w_state_code_nxt;
      r_state_valid <= w_state_valid_nxt;
      r_frame_error <= w_frame_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_uid_nxt         = r_uid;
    w_next_tx_nxt     = r_next_tx;
    w_state_code_nxt  = r_state_code;
    w_state_valid_nxt = 1'b0;
    w_frame_error_nxt = 1'b0;
    if (w_abort) begin
      w_state_nxt       = S_IDLE;
      w_next_tx_nxt     = IDLE_BYTE;
      w_frame_error_nxt = 1'b1;
    end else if (w_rx_valid) begin
      if (w_rx_byte == CMD_UID) begin
        w_uid_nxt     = uid_present ? uid_in : '0;
        w_next_tx_nxt = uid_present ? uid_in[31:24] : '0;
        w_idx_nxt     = 3'd1;
        w_state_nxt   = S_UID;
      end else begin
        case (r_state)
          S_UID: begin
            if (r_idx == 3'd4) begin
              w_next_tx_nxt = IDLE_BYTE;
              w_state_nxt   = S_STATE;
            end else begin
              w_next_tx_nxt = uid_byte(r_uid, r_idx[1:0]);
              w_idx_nxt     = r_idx + 3'd1;
            end
          end
          S_STATE: begin
            // Unsigned offset below 4 covers exactly CMD_STATE_BASE..CMD_STATE_BASE+3.
            if (w_state_ofs < 8'd4) begin
              w_state_code_nxt  = w_state_ofs[1:0];
              w_state_valid_nxt = 1'b1;
            end else begin
              w_frame_error_nxt = 1'b1;
            end
            w_state_nxt   = S_IDLE;
            w_next_tx_nxt = IDLE_BYTE;
          end
          default: begin
            w_state_nxt   = S_IDLE;
            w_next_tx_nxt = IDLE_BYTE;
          end
        endcase
      end
    end
  end

  assign state_code  = r_state_code;
  assign state_valid = r_state_valid;
  assign frame_error = r_frame_error;
  assign rx_byte     = w_rx_byte;
  assign rx_valid    = w_rx_valid;

endmodule
